// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM state enum, funct3 encodings and the helpers for legality and alignment.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // Wide enough for the largest supported bus timeout (1023).
    localparam int TMO_W = 10;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == LS_B) || (f3 == LS_H) || (f3 == LS_W);
        return (f3 == LS_B) || (f3 == LS_H) || (f3 == LS_W) ||
               (f3 == LS_BU) || (f3 == LS_HU);
    endfunction

    // size is funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b01:   return ~lo[0];
            2'b10:   return (lo == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side and data-bus signals of the load/store unit.
// master is the LSU's own view; slave is the view of the decoder/bus environment.
interface lsu_if;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  memSignWidth;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] loadData;
    logic        loadValid;
    logic        memErr;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [3:0]  busBe;
    logic [31:0] busWdata;
    logic        busAck;
    logic [31:0] busRdata;

    modport master (
        input  memRead, memWrite, memSignWidth, addr, wdata, busAck, busRdata,
        output stall, loadData, loadValid, memErr,
               busReq, busWe, busAddr, busBe, busWdata
    );

    modport slave (
        output memRead, memWrite, memSignWidth, addr, wdata, busAck, busRdata,
        input  stall, loadData, loadValid, memErr,
               busReq, busWe, busAddr, busBe, busWdata
    );
endinterface

// File: rtl/lsu_lane.sv
// Combinational byte-lane steering: byte enables and replicated write data for the access,
// plus lane selection and sign/zero extension of the returned read word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_f3,
    input  logic [1:0]  i_ld_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ldata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_size)
            2'b00: begin
                o_be    = 4'b0001 << i_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = i_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = i_rdata[{i_ld_lo, 3'b000} +: 8];
    assign w_half = i_ld_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        case (i_ld_f3)
            LS_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
            LS_H:    o_ldata = {{16{w_half[15]}}, w_half};
            LS_BU:   o_ldata = {24'd0, w_byte};
            LS_HU:   o_ldata = {16'd0, w_half};
            default: o_ldata = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request/ack bus transaction per load or store, stalling the front end
// from issue until the cycle the result is presented; bad accesses raise memErr without a bus cycle.
module lsu
    import lsu_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.master lsu_io
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUS_TIMEOUT - 1);

    lsu_state_t       r_state;
    logic [TMO_W-1:0] r_cnt;
    logic [2:0]       r_f3;
    logic [1:0]       r_lo;
    logic             r_bus_req;
    logic             r_bus_we;
    logic [31:0]      r_bus_addr;
    logic [3:0]       r_bus_be;
    logic [31:0]      r_bus_wdata;
    logic [31:0]      r_load_data;
    logic             r_load_valid;
    logic             r_mem_err;

    logic        w_access;
    logic        w_ok;
    logic        w_issue;
    logic        w_bad;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ldata;

    assign w_access = lsu_io.memRead | lsu_io.memWrite;
    assign w_ok     = f3_legal(lsu_io.memWrite, lsu_io.memSignWidth) &&
                      is_aligned(lsu_io.memSignWidth[1:0], lsu_io.addr[1:0]);
    assign w_issue  = (r_state == IDLE) && w_access && w_ok;
    assign w_bad    = (r_state == IDLE) && w_access && !w_ok;

    lsu_lane u_lane (
        .i_size  (lsu_io.memSignWidth[1:0]),
        .i_lo    (lsu_io.addr[1:0]),
        .i_wdata (lsu_io.wdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .i_ld_f3 (r_f3),
        .i_ld_lo (r_lo),
        .i_rdata (lsu_io.busRdata),
        .o_ldata (w_ldata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_f3         <= '0;
            r_lo         <= '0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_be     <= '0;
            r_bus_wdata  <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_mem_err    <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_mem_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_issue) begin
                        r_state     <= REQ;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= lsu_io.memWrite;
                        r_bus_addr  <= {lsu_io.addr[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_f3        <= lsu_io.memSignWidth;
                        r_lo        <= lsu_io.addr[1:0];
                    end else if (w_bad) begin
                        r_mem_err <= 1'b1;
                    end
                end
                REQ: begin
                    // An ack in the final allowed cycle still completes the access.
                    if (lsu_io.busAck) begin
                        r_bus_req    <= 1'b0;
                        r_load_data  <= r_bus_we ? 32'd0 : w_ldata;
                        r_load_valid <= ~r_bus_we;
                        r_state      <= DONE;
                    end else if (r_cnt == TMO_LAST) begin
                        r_bus_req   <= 1'b0;
                        r_load_data <= '0;
                        r_mem_err   <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lsu_io.stall     = !rst && (w_issue || (r_state == REQ));
    assign lsu_io.loadData  = r_load_data;
    assign lsu_io.loadValid = r_load_valid;
    assign lsu_io.memErr    = r_mem_err;
    assign lsu_io.busReq    = r_bus_req;
    assign lsu_io.busWe     = r_bus_we;
    assign lsu_io.busAddr   = r_bus_addr;
    assign lsu_io.busBe     = r_bus_be;
    assign lsu_io.busWdata  = r_bus_wdata;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the fetch/decode stage in the single-issue RISC-V core. It consumes the decoder's `memRead`/`memWrite`/`memSignWidth` controls, the ALU-computed effective address and `rs2Data`. It runs a request/acknowledge transaction on the data bus with byte-lane steering and sign/zero extension. It holds `stall` high so the PC and the current instruction stay frozen until the load data is ready for register writeback.

## Interface
- `BUS_TIMEOUT`, default 255: REQ cycles without `busAck` before the access is abandoned with `memErr`; range 1..1023.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `memRead`  in  1  decoded load
- `memWrite`  in  1  decoded store; wins if both set
- `memSignWidth`  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW
- `addr`  in  32  effective address (ALU result)
- `wdata`  in  32  store data (`rs2Data`)
- `stall`  out  1  freeze PC/decode
- `loadData`  out  32  extended load result (writeback source `rdSrc`=01)
- `loadValid`  out  1  one-cycle pulse, `loadData` valid
- `memErr`  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout
- `busReq`  out  1  request, held until ack
- `busWe`  out  1  1 = write
- `busAddr`  out  32  word address, `[1:0]`=00
- `busBe`  out  4  byte enables
- `busWdata`  out  32  lane-replicated write data
- `busAck`  in  1  completion, sampled while `busReq`=1
- `busRdata`  in  32  read word, valid with `busAck`

## Operation
- States:
  - IDLE: no access in progress.
  - REQ: `busReq` held, waiting for `busAck`.
  - DONE: one cycle, results presented.
- IDLE with `memRead|memWrite`, legal and aligned:
  - capture `busAddr={addr[31:2],2'b00}`, `busWe`, `busBe`, `busWdata`, funct3 and `addr[1:0]`.
  - go to REQ; `stall`=1 combinationally this cycle.
- Illegal or misaligned access: no bus cycle, no `stall`, and `memErr`=1 the next cycle.
  - Illegal funct3 means load 011/110/111, store ≥011.
  - Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠00.
- Lane steering:
  - Byte: `busBe`=`4'b0001<<addr[1:0]`, `busWdata`=`{4{wdata[7:0]}}`.
  - Half: `busBe`=0011 or 1100, `busWdata`=`{2{wdata[15:0]}}`.
  - Word: `busBe`=1111.
- Load extraction: select the lane by captured `addr[1:0]`; sign-extend for 000/001, zero-extend for 100/101.
- REQ, `busAck`=1: register the extracted data into `loadData` (stores: 0), go to DONE.
- REQ, no ack: the timeout counter increments. At `BUS_TIMEOUT`, drop the request, `loadData`=0, `memErr`=1, go to DONE.
- DONE:
  - `stall`=0 and `loadValid`=1 (load, no error).
  - the decoder still holds the same instruction, so the `rd` write happens at this edge and PC advances.
  - go to IDLE unconditionally; no new access starts from DONE.
- `rst`, including mid-REQ: next state IDLE; `busReq` deasserts at the following edge and the outstanding ack is ignored.

## Timing
- Reset values: `busReq`=0, `busWe`=0, `busAddr`=0, `busBe`=0, `busWdata`=0, `loadData`=0, `loadValid`=0, `memErr`=0, counter 0; `stall` forced 0 while `rst`=1.
- `stall`=(IDLE & access & legal & aligned) | REQ.
- Latency with ack at the k-th REQ cycle (k≥1): issue cycle, k REQ cycles, then DONE; total k+2 cycles, stalled for k+1.
- `busAddr`/`busBe`/`busWdata`/`busWe` stable through REQ; ack on the first REQ cycle is legal.
- Non-memory instructions pass with zero-cycle impact.

## Structure
- Shared package `lsu_pkg`: state enum (IDLE, REQ, DONE); funct3 constants `LS_B`, `LS_H`, `LS_W`, `LS_BU`, `LS_HU`; timeout counter width.
- Sub-module `lsu_lane`: combinational store lane/BE generation and load extract/extend.
- `lsu` holds the FSM, capture registers and counter.

## Test plan
- LW at 0x100, ack after 2 REQ cycles, `busRdata`=0xDEADBEEF: `busAddr`=0x100, `busBe`=1111, `stall` high 3 cycles, then `loadData`=0xDEADBEEF with `loadValid` pulse.
- LB at 0x103 with rdata 0x80xxxxxx → 0xFFFFFF80; LBU same → 0x00000080; LHU at 0x102 with rdata 0xBEEFxxxx → 0x0000BEEF.
- SB at 0x201, `wdata`=0x12345678: `busWe`=1, `busBe`=0010, `busWdata`=0x78787878, `busAddr`=0x200, no `loadValid`.
- LW at 0x102: no `busReq`, `stall`=0, `memErr` pulse next cycle; same for a load with funct3 011.
- No ack with `BUS_TIMEOUT`=4: `busReq` drops after 4 REQ cycles, `memErr` pulse, `loadData`=0, FSM returns to IDLE.
- `rst` on the second REQ cycle: `busReq`=0 next cycle, all outputs at reset values, and a late `busAck` produces no `loadValid`.
